// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic commands into MIPS machine words for the
// control-decoder subset and streams them, with IM addresses, to the loader.
// LI expands to LUI+ORI when the constant has a non-zero upper half.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [4:0]  cmd_rs,
   input  logic [4:0]  cmd_rt,
   input  logic [4:0]  cmd_rd,
   input  logic [31:0] cmd_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic [15:0] word_cnt
);

   typedef enum logic {
      IDLE,
      LI2
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_ORI  = 4'd2,
      OP_LW   = 4'd3,
      OP_SW   = 4'd4,
      OP_BEQ  = 4'd5,
      OP_LUI  = 4'd6,
      OP_SLL  = 4'd7,
      OP_J    = 4'd8,
      OP_JAL  = 4'd9,
      OP_JR   = 4'd10,
      OP_JALR = 4'd11,
      OP_LB   = 4'd12,
      OP_SB   = 4'd13,
      OP_LI   = 4'd14,
      OP_NOP  = 4'd15
   } op_t;

   state_t      state;
   state_t      state_nxt;
   op_t         op;
   logic [31:0] enc_word;
   logic        li_two;
   logic        cmd_xfer;
   logic        out_xfer;
   logic [4:0]  li_rt;
   logic [15:0] li_lo;

   assign op = op_t'(cmd_op);

   // Encode the presented command; ignored fields are forced to zero.
   always_comb begin
      enc_word = '0;
      li_two   = 1'b0;
      case (op)
         OP_ADD:  enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h20};
         OP_SUB:  enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h22};
         OP_ORI:  enc_word = {6'h0D, cmd_rs, cmd_rt, cmd_imm[15:0]};
         OP_LW:   enc_word = {6'h23, cmd_rs, cmd_rt, cmd_imm[15:0]};
         OP_SW:   enc_word = {6'h2B, cmd_rs, cmd_rt, cmd_imm[15:0]};
         OP_BEQ:  enc_word = {6'h04, cmd_rs, cmd_rt, cmd_imm[15:0]};
         OP_LUI:  enc_word = {6'h0F, 5'd0, cmd_rt, cmd_imm[15:0]};
         OP_SLL:  enc_word = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_imm[4:0], 6'h00};
         OP_J:    enc_word = {6'h02, cmd_imm[25:0]};
         OP_JAL:  enc_word = {6'h03, cmd_imm[25:0]};
         OP_JR:   enc_word = {6'h00, cmd_rs, 15'd0, 6'h08};
         OP_JALR: enc_word = {6'h00, cmd_rs, 5'd0, cmd_rd, 5'd0, 6'h09};
         OP_LB:   enc_word = {6'h20, cmd_rs, cmd_rt, cmd_imm[15:0]};
         OP_SB:   enc_word = {6'h28, cmd_rs, cmd_rt, cmd_imm[15:0]};
         OP_LI: begin
            if (cmd_imm[31:16] != '0) begin
               li_two   = 1'b1;
               enc_word = {6'h0F, 5'd0, cmd_rt, cmd_imm[31:16]};
            end else begin
               enc_word = {6'h0D, 5'd0, cmd_rt, cmd_imm[15:0]};
            end
         end
         OP_NOP:  enc_word = '0;
         default: enc_word = '0;
      endcase
   end

   // Handshakes and next state: LI2 holds off new commands until the ORI is loaded.
   always_comb begin
      state_nxt = state;
      cmd_ready = (state == IDLE) && (!out_valid || out_ready) && !reset;
      cmd_xfer  = cmd_valid && cmd_ready;
      out_xfer  = out_valid && out_ready;
      if (state == IDLE && cmd_xfer && li_two) begin
         state_nxt = LI2;
      end else if (state == LI2 && out_xfer) begin
         state_nxt = IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Output word register; a new word may replace the departing one in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= BASE_ADDR;
         word_cnt  <= '0;
         li_rt     <= '0;
         li_lo     <= '0;
      end else begin
         if (out_xfer) begin
            out_addr <= out_addr + 32'd4;
            word_cnt <= word_cnt + 16'd1;
         end
         if (cmd_xfer) begin
            out_valid <= 1'b1;
            out_instr <= enc_word;
            li_rt     <= cmd_rt;
            li_lo     <= cmd_imm[15:0];
         end else if (state == LI2 && out_xfer) begin
            out_valid <= 1'b1;
            out_instr <= {6'h0D, li_rt, li_rt, li_lo};
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
